// File: rtl/score_seg_scan.sv
// score_seg_scan: captures a packed BCD score and scans it onto a common-anode seven-segment display
module score_seg_scan #(
   parameter int DIGITS   = 5,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic                  bcd_valid,
   input  logic                  blank_lz,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg
);
   localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   logic [4*DIGITS-1:0] sh;
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [DIGITS-1:0]   blank;
   logic [DIGITS-1:0]   an_d;
   logic [6:0]          seg_d;
   logic [3:0]          dig;
   logic                off;
   logic                zero_run;
   logic                wrap;
   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0:    dec = 7'h40;
         4'd1:    dec = 7'h79;
         4'd2:    dec = 7'h24;
         4'd3:    dec = 7'h30;
         4'd4:    dec = 7'h19;
         4'd5:    dec = 7'h12;
         4'd6:    dec = 7'h02;
         4'd7:    dec = 7'h78;
         4'd8:    dec = 7'h00;
         4'd9:    dec = 7'h10;
         default: dec = 7'h7F;
      endcase
   endfunction
   assign wrap = cnt == CW'(SCAN_DIV - 1);
   // leading-zero mask from the top digit down, then the selected digit's anode/segment pattern
   always_comb begin
      blank    = '0;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run && (sh[4*i +: 4] == 4'd0);
         blank[i] = blank_lz && zero_run;
      end
      dig   = sh[{idx, 2'b00} +: 4];
      off   = blank[idx] || (dig > 4'd9);
      an_d  = off ? '1 : ~(DIGITS'(1) << idx);
      seg_d = off ? 7'h7F : dec(dig);
   end
   // shadow capture, slot/digit counters and the single output stage that keeps an one-hot-low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh  <= '0;
         cnt <= '0;
         idx <= '0;
         an  <= '1;
         seg <= 7'h7F;
      end else begin
         if (bcd_valid) sh <= bcd_in;
         cnt <= wrap ? '0 : cnt + 1'b1;
         if (wrap) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         an  <= an_d;
         seg <= seg_d;
      end
   end
endmodule

// File: tb/tb_score_seg_scan.sv
// tb_score_seg_scan: directed checks of capture, scanning, blanking and reset behaviour
module tb_score_seg_scan;
   localparam int DIGITS   = 5;
   localparam int SCAN_DIV = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [19:0] bcd_in = '0;
   logic        bcd_valid = 1'b0;
   logic        blank_lz = 1'b0;
   logic [4:0]  an;
   logic [6:0]  seg;
   int checks = 0;
   int fails  = 0;

   score_seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
      .blank_lz(blank_lz), .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   task automatic reset_dut();
      rst_n = 1'b0;
      bcd_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      blank_lz = 1'b1;
      rst_n = 1'b0;
      bcd_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (an !== 5'h1F || seg !== 7'h7F) begin
            fails++;
            $display("FAIL reset_hold: an=%b seg=%h, expected an=11111 seg=7f", an, seg);
         end
      end
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         logic [4:0] ea;
         logic [6:0] es;
         @(negedge clk);
         ea = ((k / 4) % 5 == 0) ? 5'h1E : 5'h1F;
         es = ((k / 4) % 5 == 0) ? 7'h40 : 7'h7F;
         checks++;
         if (an !== ea || seg !== es) begin
            fails++;
            $display("FAIL zero_display cyc%0d: an=%b seg=%h, expected an=%b seg=%h", k, an, seg, ea, es);
         end
      end
   endtask

   task automatic test_full_scan();
      logic [4:0] ea [5] = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F};
      logic [6:0] es [5] = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
      reset_dut();
      blank_lz = 1'b0;
      bcd_in = 20'h12345;
      bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      repeat (19) @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (an !== ea[k/4] || seg !== es[k/4]) begin
            fails++;
            $display("FAIL full_scan cyc%0d: an=%b seg=%h, expected an=%b seg=%h", k, an, seg, ea[k/4], es[k/4]);
         end
      end
   endtask

   task automatic test_lz_blank();
      logic [4:0] ea [5] = '{5'h1E, 5'h1D, 5'h1B, 5'h1F, 5'h1F};
      logic [6:0] es [5] = '{7'h78, 7'h40, 7'h10, 7'h7F, 7'h7F};
      reset_dut();
      blank_lz = 1'b1;
      bcd_in = 20'h00907;
      bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      repeat (19) @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (an !== ea[k/4] || seg !== es[k/4]) begin
            fails++;
            $display("FAIL lz_blank cyc%0d: an=%b seg=%h, expected an=%b seg=%h", k, an, seg, ea[k/4], es[k/4]);
         end
      end
   endtask

   task automatic test_decode_68();
      logic [4:0] ea [5] = '{5'h1E, 5'h1D, 5'h1F, 5'h1F, 5'h1F};
      logic [6:0] es [5] = '{7'h00, 7'h02, 7'h7F, 7'h7F, 7'h7F};
      reset_dut();
      blank_lz = 1'b1;
      bcd_in = 20'h00068;
      bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      repeat (19) @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (an !== ea[k/4] || seg !== es[k/4]) begin
            fails++;
            $display("FAIL decode_68 cyc%0d: an=%b seg=%h, expected an=%b seg=%h", k, an, seg, ea[k/4], es[k/4]);
         end
      end
   endtask

   task automatic test_back_to_back();
      reset_dut();
      blank_lz = 1'b0;
      bcd_in = 20'h00001;
      bcd_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (an !== 5'h1E || seg !== 7'h40) begin
         fails++;
         $display("FAIL b2b_old: an=%b seg=%h, expected an=11110 seg=40", an, seg);
      end
      bcd_in = 20'h00002;
      @(negedge clk);
      bcd_valid = 1'b0;
      checks++;
      if (an !== 5'h1E || seg !== 7'h79) begin
         fails++;
         $display("FAIL b2b_first: an=%b seg=%h, expected an=11110 seg=79", an, seg);
      end
      @(negedge clk);
      checks++;
      if (an !== 5'h1E || seg !== 7'h24) begin
         fails++;
         $display("FAIL b2b_last: an=%b seg=%h, expected an=11110 seg=24", an, seg);
      end
      @(negedge clk);
      checks++;
      if (seg !== 7'h24) begin
         fails++;
         $display("FAIL b2b_hold: seg=%h, expected 24", seg);
      end
      checks++;
      if (dut.sh !== 20'h00002) begin
         fails++;
         $display("FAIL b2b_sh: sh=%h, expected 00002", dut.sh);
      end
   endtask

   task automatic test_illegal_onehot();
      reset_dut();
      blank_lz = 1'b1;
      bcd_in = 20'h0000A;
      bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      repeat (19) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (an !== 5'h1F || seg !== 7'h7F) begin
            fails++;
            $display("FAIL illegal_bcd cyc%0d: an=%b seg=%h, expected an=11111 seg=7f", k, an, seg);
         end
      end
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         checks++;
         if ($countones(~an) > 1) begin
            fails++;
            $display("FAIL onehot cyc%0d: an=%b, expected at most one low bit", k, an);
         end
         bcd_in = 20'($urandom);
         bcd_valid = 1'($urandom_range(0, 1));
         blank_lz = 1'($urandom_range(0, 1));
      end
      bcd_valid = 1'b0;
   endtask

   task automatic test_mid_reset();
      reset_dut();
      blank_lz = 1'b0;
      bcd_in = 20'h12345;
      bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      repeat (13) @(negedge clk);
      checks++;
      if (dut.cnt !== 2'd2 || dut.idx !== 3'd3 || an !== 5'h17 || seg !== 7'h24) begin
         fails++;
         $display("FAIL mid_pre: cnt=%0d idx=%0d an=%b seg=%h, expected cnt=2 idx=3 an=10111 seg=24", dut.cnt, dut.idx, an, seg);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (an !== 5'h1F || seg !== 7'h7F) begin
         fails++;
         $display("FAIL mid_async_out: an=%b seg=%h, expected an=11111 seg=7f", an, seg);
      end
      checks++;
      if (dut.sh !== 20'h0 || dut.cnt !== 2'd0 || dut.idx !== 3'd0) begin
         fails++;
         $display("FAIL mid_async_state: sh=%h cnt=%0d idx=%0d, expected all 0", dut.sh, dut.cnt, dut.idx);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (an !== 5'h1E || seg !== 7'h40) begin
         fails++;
         $display("FAIL mid_restart: an=%b seg=%h, expected an=11110 seg=40", an, seg);
      end
      repeat (3) @(negedge clk);
      @(negedge clk);
      checks++;
      if (an !== 5'h1D || seg !== 7'h40) begin
         fails++;
         $display("FAIL mid_next_digit: an=%b seg=%h, expected an=11101 seg=40", an, seg);
      end
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_lz_blank();
      test_decode_68();
      test_back_to_back();
      test_illegal_onehot();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/score_seg_scan.md
# score_seg_scan

Time-multiplexed seven-segment driver for the score path. It captures the packed BCD score produced by the binary-to-BCD converter and holds it in a shadow register. It then scans one digit per refresh slot onto a common-anode display, with optional leading-zero blanking. It sits directly downstream of the BCD converter and drives the board display pins.

## Interface
- `DIGITS`, default 5: number of BCD digits / anodes. 5 matches a 16-bit score, i.e. a 20-bit BCD word.
- `SCAN_DIV`, default 50000: clock cycles per digit slot. Must be ≥2.
- `clk` input 1: system clock. One clock domain only.
- `rst_n` input 1: reset, asynchronous, active-low.
- `bcd_in` input 4*DIGITS: packed BCD. Digit i is `bcd_in[4i+3:4i]`; digit 0 is the least significant, rightmost digit.
- `bcd_valid` input 1: capture strobe. Sampled every cycle.
- `blank_lz` input 1: 1 enables leading-zero blanking. Sampled every cycle.
- `an` output DIGITS: anode enables, active-low. `an[i]` selects digit i.
- `seg` output 7: segments, active-low, ordered {g,f,e,d,c,b,a}.

## Operation
- Shadow register `sh`, width 4*DIGITS:
  - Loads `bcd_in` on any clock edge where `bcd_valid`=1.
  - Otherwise holds its value.
  - Back-to-back strobes: the last one wins. There is no handshake back-pressure; the upstream block may strobe at any rate.
- Slot counter `cnt`, range 0..SCAN_DIV-1:
  - Increments every cycle.
  - At SCAN_DIV-1 it wraps to 0, and digit index `idx` advances (DIGITS-1 wraps to 0).
- Blank mask, combinational from `sh` and `blank_lz`:
  - Digit i (i≥1) is blanked iff `blank_lz`=1 and digits i..DIGITS-1 of `sh` are all zero.
  - Digit 0 is never blanked, so a score of 0 shows a single "0".
- Output register, updated every cycle from the current `idx`, `sh` and mask:
  - Digit not blanked and value 0–9: `an` = all ones except bit `idx` = 0; `seg` = decode(value).
  - Digit blanked, or value 10–15 (illegal BCD): `an` = all ones, `seg` = 7'h7F.
- Decode table, active-low gfedcba: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- At most one `an` bit is low in any cycle. This is a glitch-free one-hot-low guarantee, because `an` and `seg` come from the same register stage.

## Timing
- Reset values, asynchronous, while `rst_n`=0: `an` = all ones; `seg` = 7'h7F; `sh` = 0; `cnt` = 0; `idx` = 0.
- After reset release:
  - The first rising edge drives digit 0, showing "0" on `an[0]`.
  - Each digit is held for exactly SCAN_DIV cycles.
  - Full frame = DIGITS*SCAN_DIV cycles.
- Capture latency:
  - `bcd_valid` high at edge t → `sh` updated at t.
  - `an`/`seg` reflect the new value at edge t+1, if that digit is currently selected.
- `blank_lz` change: effective on `an`/`seg` at the next edge.
- Slot boundary:
  - At the edge where `cnt` wraps, `idx` changes.
  - `an`/`seg` switch to the new digit one edge later.
  - The old digit is therefore shown for exactly SCAN_DIV cycles.
- A capture in the same cycle as a slot wrap: both take effect. The next digit is displayed from the new `sh`.
- Reset asserted mid-slot: all state returns to reset values immediately. No partial digit is retained.

## Test plan
Bench parameters for all scenarios: DIGITS=5, SCAN_DIV=4.

1. **Reset and zero display.** Hold `rst_n`=0 for 3 cycles, then release.
   - During reset: `an`=5'b11111, `seg`=7F.
   - With `blank_lz`=1: `an[0]`=0 with `seg`=40 for 4 cycles, then 16 cycles of `an`=11111 / `seg`=7F. The pattern repeats with period 20.
2. **Full scan, no blanking.** `blank_lz`=0; strobe `bcd_in`=20'h12345.
   - Successive 4-cycle slots show `an` = 11110/seg 12, 11101/seg 19, 11011/seg 30, 10111/seg 24, 01111/seg 79.
3. **Leading-zero blanking.** `blank_lz`=1; `bcd_in`=20'h00907.
   - Digits 0–2 are shown (`seg` 78, 40, 10).
   - Digits 3 and 4 are blanked (`an`=11111).
   - The internal zero at digit 1 is not blanked.
4. **Capture timing and last-strobe-wins.**
   - Strobe 20'h00001, then 20'h00002 on the next cycle, during the digit-0 slot. `seg`=79 for one cycle, then 24.
   - `sh` = 20'h00002 afterwards.
5. **Illegal BCD and one-hot check.** `bcd_in`=20'h0000A, `blank_lz`=1.
   - The digit-0 slot drives `an`=11111, `seg`=7F.
   - Over 1000 random cycles the assertion "popcount(~an) ≤ 1" never fails.
6. **Mid-slot reset.** Assert `rst_n`=0 at `cnt`=2, `idx`=3.
   - Outputs go to reset values asynchronously, without waiting for a clock edge.
   - After release, scanning restarts at `idx`=0 with `sh`=0.
